counter_sched: RTL and testbench

COUNTER_SCHED -- requirements
Module: counter_sched

---
 rtl/counter_sched_pkg.sv | 18 +
 rtl/rr_arb2.sv | 35 +++
 rtl/counter_sched.sv | 112 +++++++++++
 tb/tb_counter_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter scheduler: FSM state encoding,
// operation codes and the default datapath width.
package counter_sched_pkg;

  localparam int WIDTH_DEF = 3;

  // Operation codes, sampled per requester together with its request bit.
  localparam logic OP_COUNT = 1'b0;
  localparam logic OP_LOAD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The one-hot grant is combinational from the
// request vector. The priority pointer moves only when the grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,       // asynchronous, active-low
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  // Requester that wins a tie: 0 after reset, otherwise the one not most
  // recently granted.
  logic       r_pri;
  logic [1:0] w_gnt;

  // Pick the winner. A lone request always wins. A tie goes to the pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_gnt = 2'b00;
    if (i_req == 2'b11) w_gnt = r_pri ? 2'b10 : 2'b01;
    else                w_gnt = i_req;
  end

  assign o_gnt = w_gnt;

  // Hand priority to the other requester whenever a grant is taken.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    if (!rst)          r_pri <= 1'b0;
    else if (i_accept) r_pri <= w_gnt[0];
  end

endmodule

// File: rtl/counter_sched.sv
// Counter scheduler: arbitrates two requesters for an external counter and
// performs either a one-cycle load or a run of N increment strobes. It then
// signals completion with a done pulse.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,       // asynchronous, active-low
  input  logic [1:0]       req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] arg0,
  input  logic [WIDTH-1:0] arg1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             ld,
  output logic             inc,
  output logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out,
  output logic             wrap,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state, w_next;
  logic [1:0]       r_gnt;
  logic [WIDTH-1:0] r_arg;
  logic [WIDTH-1:0] r_rem;
  logic             r_wrap;

  logic [1:0]       w_arb_gnt;
  logic             w_accept;
  logic             w_sel_op;
  logic [WIDTH-1:0] w_sel_arg;

  // Grants are only taken from IDLE. This also forces the idle cycle between
  // operations.
  assign w_accept  = (r_state == ST_IDLE) && (req != 2'b00);
  assign w_sel_op  = w_arb_gnt[1] ? op[1] : op[0];
  assign w_sel_arg = w_arb_gnt[1] ? arg1  : arg0;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req),
    .i_accept (w_accept),
    .o_gnt    (w_arb_gnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic. A zero-length count goes straight to DONE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_sel_op == OP_LOAD)       w_next = ST_LOAD;
          else if (w_sel_arg != '0)      w_next = ST_COUNT;
          else                           w_next = ST_DONE;
        end
      end
      ST_LOAD:  w_next = ST_DONE;
      ST_COUNT: if (r_rem == ONE) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Latch grant and argument on acceptance, count down remaining
  // increments, and drop the grant when leaving DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt <= 2'b00;
      r_arg <= '0;
      r_rem <= '0;
    end else if (w_accept) begin
      r_gnt <= w_arb_gnt;
      r_arg <= w_sel_arg;
      r_rem <= w_sel_arg;
    end else if (r_state == ST_COUNT) begin
      r_rem <= r_rem - ONE;
    end else if (r_state == ST_DONE) begin
      r_gnt <= 2'b00;
    end
  end

  // Flag an increment that takes the counter from all-ones back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wrap <= 1'b0;
    else      r_wrap <= inc && (data_out == '1);
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    ld      = (r_state == ST_LOAD);
    inc     = (r_state == ST_COUNT);
    data_in = (r_state == ST_LOAD) ? r_arg : '0;
    done    = (r_state == ST_DONE) ? r_gnt : 2'b00;
    busy    = (r_state != ST_IDLE);
  end

  assign gnt  = r_gnt;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched with the controlled counter modelled
// beside it. Expected per-operation results are queued at issue time and
// compared when the DUT pulses done.
module tb_counter_sched;
  import counter_sched_pkg::*;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [1:0]   op  = 2'b00;
  logic [W-1:0] arg0 = '0;
  logic [W-1:0] arg1 = '0;
  logic [1:0]   gnt, done;
  logic         ld, inc, wrap, busy;
  logic [W-1:0] data_in;
  logic [W-1:0] cnt;

  always #5 clk = ~clk;

  counter_sched #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op       (op),
    .arg0     (arg0),
    .arg1     (arg1),
    .gnt      (gnt),
    .done     (done),
    .ld       (ld),
    .inc      (inc),
    .data_in  (data_in),
    .data_out (cnt),
    .wrap     (wrap),
    .busy     (busy)
  );

  // Controlled counter.
  always @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (ld)  cnt <= data_in;
    else if (inc) cnt <= cnt + 1'b1;
  end

  typedef struct {
    int           id;
    int           gnt_cyc;
    int           inc_n;
    int           ld_n;
    int           wraps;
    logic [W-1:0] fin;
    logic [W-1:0] ld_val;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] m_cnt = '0;   // model of the counter value
  logic         m_pri = 1'b0; // model of the round-robin pointer

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Queue the expected result of one operation and advance the models.
  task automatic push(input int id, input logic o, input logic [W-1:0] a);
    exp_t         e;
    logic [W-1:0] v;
    e.id = id;
    e.ld_val = '0;
    if (o == OP_LOAD) begin
      e.gnt_cyc = 2; e.inc_n = 0; e.ld_n = 1; e.wraps = 0;
      e.fin = a; e.ld_val = a;
    end else begin
      e.gnt_cyc = int'(a) + 1; e.inc_n = int'(a); e.ld_n = 0; e.wraps = 0;
      v = m_cnt;
      for (int k = 0; k < int'(a); k++) begin
        if (v == '1) e.wraps++;
        v = v + 1'b1;
      end
      e.fin = v;
    end
    m_cnt = e.fin;
    m_pri = (id == 0);
    sb.push_back(e);
  endtask

  // Monitor: accumulate per-operation activity and compare on done.
  int           a_gnt = 0, a_inc = 0, a_ld = 0, a_wrap = 0, viol = 0;
  logic [W-1:0] a_ldval = '0;
  logic         prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      a_gnt = 0; a_inc = 0; a_ld = 0; a_wrap = 0; a_ldval = '0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("idle_gap_busy", busy, 0);
      if (ld && inc) viol++;
      if (!ld && data_in != '0) viol++;
      if (gnt == 2'b11) viol++;
      if (gnt != 2'b00) begin
        a_gnt++;
        if (inc) a_inc++;
        if (ld) begin a_ld++; a_ldval = data_in; end
      end
      if (wrap) a_wrap++;
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = sb.pop_front();
          check("done_id",   done,     2'b01 << e.id);
          check("done_gnt",  gnt,      done);
          check("gnt_cyc",   a_gnt,    e.gnt_cyc);
          check("inc_cnt",   a_inc,    e.inc_n);
          check("ld_cnt",    a_ld,     e.ld_n);
          check("wrap_cnt",  a_wrap,   e.wraps);
          check("data_out",  cnt,      e.fin);
          if (e.ld_n != 0) check("ld_value", a_ldval, e.ld_val);
        end
        a_gnt = 0; a_inc = 0; a_ld = 0; a_wrap = 0; a_ldval = '0;
      end
      prev_done = (done != 2'b00);
    end
  end

  // Drop each request bit when its done is seen; bounded wait.
  task automatic wait_clear(input int budget);
    for (int i = 0; i < budget && req != 2'b00; i++) begin
      @(negedge clk);
      for (int b = 0; b < 2; b++) if (done[b]) req[b] = 1'b0;
    end
    if (req != 2'b00) begin
      check("timeout_clear", req, 0);
      req = 2'b00;
    end
  endtask

  task automatic wait_gnt(input int b, input int budget);
    int n = 0;
    while (!gnt[b] && n < budget) begin @(negedge clk); n++; end
    if (!gnt[b]) check("timeout_gnt", gnt, 2'b01 << b);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (done == 2'b00 && n < budget) begin @(negedge clk); n++; end
    if (done == 2'b00) check("timeout_done", done, 1);
  endtask

  task automatic set_op(input int id, input logic o, input logic [W-1:0] a);
    op[id] = o;
    if (id == 0) arg0 = a; else arg1 = a;
  endtask

  task automatic single(input int id, input logic o, input logic [W-1:0] a);
    set_op(id, o, a);
    push(id, o, a);
    req[id] = 1'b1;
    wait_clear(40);
  endtask

  // Both requesters at once; the model pointer decides service order.
  task automatic dual(input logic o0, input logic [W-1:0] a0,
                      input logic o1, input logic [W-1:0] a1);
    set_op(0, o0, a0);
    set_op(1, o1, a1);
    if (!m_pri) begin push(0, o0, a0); push(1, o1, a1); end
    else        begin push(1, o1, a1); push(0, o0, a0); end
    req = 2'b11;
    wait_clear(60);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 2'b00;
    m_cnt = '0;
    m_pri = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state.
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_ld", ld, 0);
    check("rst_inc", inc, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Load 5 by requester 0.
    single(0, OP_LOAD, 3'd5);
    // Preset counter to 6, then count 3 through the wrap.
    single(1, OP_LOAD, 3'd6);
    single(1, OP_COUNT, 3'd3);

    // Simultaneous requests after reset: 0, then 1, then 0 again.
    do_reset();
    dual(OP_LOAD, 3'd2, OP_COUNT, 3'd2);
    dual(OP_COUNT, 3'd1, OP_LOAD, 3'd4);

    // Zero-length count.
    single(1, OP_COUNT, 3'd0);

    // Request dropped and op/arg changed after the grant.
    set_op(0, OP_COUNT, 3'd2);
    push(0, OP_COUNT, 3'd2);
    req[0] = 1'b1;
    wait_gnt(0, 20);
    req[0] = 1'b0;
    set_op(0, OP_LOAD, 3'd7);
    wait_done(20);
    @(negedge clk);

    // Requester 1 arrives during requester 0's operation and is held off.
    set_op(0, OP_COUNT, 3'd3);
    push(0, OP_COUNT, 3'd3);
    req[0] = 1'b1;
    wait_gnt(0, 20);
    set_op(1, OP_LOAD, 3'd3);
    push(1, OP_LOAD, 3'd3);
    req[1] = 1'b1;
    wait_clear(60);

    // Reset during the second increment of a count of 4.
    set_op(0, OP_COUNT, 3'd4);
    req[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 30 && n < 2; i++) begin
      @(negedge clk);
      if (inc) n++;
    end
    check("mid_rst_inc_seen", n, 2);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ld", ld, 0);
    check("mid_rst_inc", inc, 0);
    check("mid_rst_din", data_in, 0);
    check("mid_rst_wrap", wrap, 0);
    check("mid_rst_busy", busy, 0);
    req = 2'b00;
    m_cnt = '0;
    m_pri = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    single(0, OP_LOAD, 3'd3);

    repeat (3) @(negedge clk);
    check("protocol_viol", viol, 0);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
